// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-side arbiter.
//   - Default widths/depth used as parameter defaults by the arbiter and FIFO.
//   - wb_result_t: {addr, data} long-latency result entry at default widths.
//   - Width helpers for FIFO pointers and occupancy counter.
package regfile_wb_arbiter_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_result_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry FIFO still needs a 1-bit pointer to index its array.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding long-latency results until the register file
// write port is free.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   push, push_data    write an entry (ignored when full)
//   pop                remove the head entry (ignored when empty)
//   head_data          current head entry, valid while !empty
//   count              registered occupancy, 0..DEPTH
//   full, empty        derived from count
module wb_result_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int W     = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int CNT_W = cnt_width(DEPTH),
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is read combinationally so the arbiter can pop and write in one cycle.
  assign head_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (do_pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write side of the register file. Merges the in-order pipeline writeback and
// a buffered long-latency result stream onto the single register-file write
// port, and tracks which registers still await a long-latency write.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data         pipeline writeback (always wins, no backpressure)
//   iss_valid/iss_addr               long-latency issue; marks destination busy
//   lu_valid/lu_ready/lu_addr/lu_data long-latency result handshake into the FIFO
//   busy_vec                         per-register pending long-latency write
//   RegWrite/WriteAddr/WriteData     registered register-file write port
//   stall_cnt                        only when WBARB_STALL_CNT_EN is defined:
//                                    saturating count of cycles the FIFO head
//                                    waited because the pipeline writeback won
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int NREG      = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic [NREG-1:0]   busy_vec,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [DATA_W-1:0] WriteData
`ifdef WBARB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [ENT_W-1:0]  fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              wb_win;

  logic              regwrite_reg, regwrite_next;
  logic [ADDR_W-1:0] writeaddr_reg, writeaddr_next;
  logic [DATA_W-1:0] writedata_reg, writedata_next;

  // Accept depends only on registered occupancy, so a pop at full does not
  // reopen the input until the following cycle.
  assign lu_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push = lu_valid && lu_ready;

  // An x0 writeback is swallowed and does not block the FIFO.
  assign wb_win   = wb_valid && (wb_addr != '0);
  assign fifo_pop = !wb_win && !fifo_empty;

  assign head_addr = fifo_head[DATA_W +: ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  wb_result_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({lu_addr, lu_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write port: address/data hold their last value when nothing is written.
  always_comb begin
    regwrite_next  = 1'b0;
    writeaddr_next = writeaddr_reg;
    writedata_next = writedata_reg;
    if (wb_win) begin
      regwrite_next  = 1'b1;
      writeaddr_next = wb_addr;
      writedata_next = wb_data;
    end else if (fifo_pop && (head_addr != '0)) begin
      regwrite_next  = 1'b1;
      writeaddr_next = head_addr;
      writedata_next = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_reg  <= 1'b0;
      writeaddr_reg <= '0;
      writedata_reg <= '0;
    end else begin
      regwrite_reg  <= regwrite_next;
      writeaddr_reg <= writeaddr_next;
      writedata_reg <= writedata_next;
    end
  end

  assign RegWrite  = regwrite_reg;
  assign WriteAddr = writeaddr_reg;
  assign WriteData = writedata_reg;

  // Scoreboard: x0 is never busy; for other registers a new issue in the
  // same cycle as the pop of an older result keeps the register busy.
  assign busy_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      logic busy_reg, busy_next;
      logic set_bit, clr_bit;

      assign set_bit = iss_valid && (iss_addr == ADDR_W'(gi));
      assign clr_bit = fifo_pop && (head_addr == ADDR_W'(gi));

      always_comb begin
        busy_next = busy_reg;
        if (clr_bit) begin
          busy_next = 1'b0;
        end
        if (set_bit) begin
          busy_next = 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_reg <= 1'b0;
        end else begin
          busy_reg <= busy_next;
        end
      end

      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

  // The hazard unit must never let a pipeline write target a register that
  // still has a long-latency write outstanding; the write is still performed.
  wb_busy_hazard: assert property (@(posedge clk) disable iff (!rst_n)
    !(wb_win && busy_vec[wb_addr]));

`ifdef WBARB_STALL_CNT_EN
  logic [31:0] stall_cnt_reg, stall_cnt_next;

  // Counts cycles where a buffered result waited because writeback won.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (!fifo_empty && !fifo_pop && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int NREG   = 32;

  logic              clk;
  logic              rst_n;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic [NREG-1:0]   busy_vec;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
`ifdef WBARB_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  regfile_wb_arbiter #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_addr   (lu_addr),
    .lu_data   (lu_data),
    .busy_vec  (busy_vec),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData)
`ifdef WBARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending results in arrival order, busy set, write port.
  wb_result_t        m_q[$];
  logic [NREG-1:0]   m_busy;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int unsigned       m_stall;
  logic              acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy  = '0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_stall = 0;
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, advance the
  // model, then check the registered write port just after the edge.
  task automatic step(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic iv, input logic [ADDR_W-1:0] ia,
                      input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                      output logic accepted);
    wb_result_t h;
    wb_result_t e;
    logic wbwin, pop;
    @(negedge clk);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    iss_valid = iv; iss_addr = ia;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    #1;
    chk("lu_ready", lu_ready, (m_q.size() < DEPTH));
    chk("busy_vec", busy_vec, m_busy);
    accepted = lv && (m_q.size() < DEPTH);
    wbwin = wv && (wa != 0);
    pop   = !wbwin && (m_q.size() > 0);
    if (m_q.size() > 0 && !pop && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (wbwin) begin
      m_we = 1'b1; m_addr = wa; m_data = wd;
    end else if (pop) begin
      h = m_q.pop_front();
      m_we = (h.addr != 0);
      if (m_we) begin
        m_addr = h.addr; m_data = h.data;
      end
      m_busy[h.addr] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (accepted) begin
      e.addr = la; e.data = ld;
      m_q.push_back(e);
    end
    if (iv && ia != 0) m_busy[ia] = 1'b1;
    @(posedge clk);
    #1;
    chk("RegWrite", RegWrite, m_we);
    if (m_we || !(wbwin || pop)) begin
      chk("WriteAddr", WriteAddr, m_addr);
      chk("WriteData", WriteData, m_data);
    end
`ifdef WBARB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra, la;
    logic [DATA_W-1:0] fd [3];
    int idx;
    model_reset();
    rst_n = 1'b0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; iss_valid = 0; iss_addr = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0;

    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_addr = ADDR_W'($urandom_range(1, 31)); wb_data = $urandom;
      iss_valid = 1'b1; iss_addr = ADDR_W'($urandom_range(1, 31));
      lu_valid = 1'b1; lu_addr = ADDR_W'($urandom); lu_data = $urandom;
      #1;
      chk("rst_RegWrite", RegWrite, 1'b0);
      chk("rst_busy", busy_vec, '0);
      chk("rst_lu_ready", lu_ready, 1'b1);
      chk("rst_WriteAddr", WriteAddr, '0);
      chk("rst_WriteData", WriteData, '0);
    end
    @(negedge clk);
    wb_valid = 0; iss_valid = 0; lu_valid = 0;
    rst_n = 1'b1;

    // Pipeline writeback only.
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, acc);
    chk("wb_only_addr", WriteAddr, 5);
    idle();

    // Contention: buffered x7 waits behind a writeback to x3.
    step(0, 0, 0, 1, 7, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 1, 7, 32'h11, acc);
    step(1, 3, 32'h33, 0, 0, 0, 0, 0, acc);
    chk("contend_first", WriteAddr, 3);
    idle();
    chk("contend_second", WriteAddr, 7);
    idle();
    chk("contend_busy7", busy_vec[7], 1'b0);

    // Full: writeback held while three results are offered.
    for (int i = 0; i < 3; i++) fd[i] = $urandom;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step((c < 4), ADDR_W'(c + 1), $urandom, 0, 0,
           (idx < 3), ADDR_W'(10 + idx), fd[idx < 3 ? idx : 0], acc);
      if (acc) idx++;
    end
    chk("full_all_accepted", idx, 3);

    // Register 0 from both sources.
    step(0, 0, 0, 1, 0, 1, 0, 32'h5A5A, acc);
    chk("x0_no_write", RegWrite, 1'b0);
    idle();
    idle();
    chk("x0_busy0", busy_vec[0], 1'b0);

    // Scoreboard race: reissue to x9 in the cycle its old result pops.
    step(0, 0, 0, 1, 9, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 1, 9, 32'h99, acc);
    step(0, 0, 0, 1, 9, 0, 0, 0, acc);
    idle();
    chk("race_busy9", busy_vec[9], 1'b1);

    // Randomized traffic; writebacks never target busy registers.
    for (int c = 0; c < 400; c++) begin
      ra = ADDR_W'($urandom);
      if (m_busy[ra]) ra = 0;
      la = ADDR_W'($urandom);
      step(($urandom_range(0, 2) == 0), ra, $urandom,
           ($urandom_range(0, 3) == 0), ADDR_W'($urandom),
           ($urandom_range(0, 1) == 1), la, $urandom, acc);
    end

    // Mid-operation reset drops buffered results and busy bits.
    step(0, 0, 0, 1, 20, 1, 20, 32'hAA, acc);
    step(1, 1, 32'h1, 0, 0, 1, 21, 32'hBB, acc);
    @(negedge clk);
    wb_valid = 0; iss_valid = 0; lu_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_vec, '0);
    chk("mid_rst_RegWrite", RegWrite, 1'b0);
    chk("mid_rst_lu_ready", lu_ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
